// File: rtl/rr_alu_sequencer_pkg.sv
// Shared encodings for the register-register ALU sequencer: state codes,
// instruction opcodes and the ALU operation codes it emits.
package rr_alu_sequencer_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'b0000,
      S_T0   = 4'b0111,
      S_T1   = 4'b1000,
      S_T2   = 4'b1001,
      S_T3   = 4'b1010,
      S_T4   = 4'b1011,
      S_T5   = 4'b1100
   } state_t;

   localparam logic [4:0] OPC_ADD = 5'b00011;
   localparam logic [4:0] OPC_SUB = 5'b00100;
   localparam logic [4:0] OPC_AND = 5'b00101;
   localparam logic [4:0] OPC_OR  = 5'b00110;
   localparam logic [4:0] OPC_SHR = 5'b00111;
   localparam logic [4:0] OPC_SHL = 5'b01000;
   localparam logic [4:0] OPC_ROR = 5'b01001;
   localparam logic [4:0] OPC_ROL = 5'b01010;
   localparam logic [4:0] OPC_NEG = 5'b10001;
   localparam logic [4:0] OPC_NOT = 5'b10010;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_ROR = 4'd6;
   localparam logic [3:0] ALU_ROL = 4'd7;
   localparam logic [3:0] ALU_NEG = 4'd8;
   localparam logic [3:0] ALU_NOT = 4'd9;

   typedef struct packed {
      logic       legal;
      logic       unary;
      logic [3:0] alu_op;
   } dec_t;

endpackage

// File: rtl/rr_alu_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/memory status in, control strobes
// and status out. The sequencer uses the slave view.
interface rr_alu_sequencer_if #(
   parameter int REG_BITS = 4,
   parameter int DATA_W   = 32
);
   localparam int NUM_REGS = 2**REG_BITS;

   logic                Start;
   logic                Mem_ready;
   logic [DATA_W-1:0]   IR;
   logic                PCout, Zlowout, MDRout, MARin, Zin, PCin;
   logic                MDRin, IRin, Yin, IncPC, Read;
   logic [NUM_REGS-1:0] Rout, Rin;
   logic [3:0]          Alu_op;
   logic                Busy, Done, Illegal;

   modport master (
      output Start, Mem_ready, IR,
      input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
      input  Rout, Rin, Alu_op, Busy, Done, Illegal
   );

   modport slave (
      input  Start, Mem_ready, IR,
      output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
      output Rout, Rin, Alu_op, Busy, Done, Illegal
   );
endinterface

// File: rtl/rr_opcode_decode.sv
// Combinational opcode classifier: legal/unary flags and the ALU code.
module rr_opcode_decode
   import rr_alu_sequencer_pkg::*;
#(
   parameter int OPC_W = 5
) (
   input  logic [OPC_W-1:0] opc,
   output dec_t             dec
);

   always_comb begin
      dec       = '0;
      dec.legal = 1'b1;
      case (opc)
         OPC_W'(OPC_ADD): dec.alu_op = ALU_ADD;
         OPC_W'(OPC_SUB): dec.alu_op = ALU_SUB;
         OPC_W'(OPC_AND): dec.alu_op = ALU_AND;
         OPC_W'(OPC_OR):  dec.alu_op = ALU_OR;
         OPC_W'(OPC_SHR): dec.alu_op = ALU_SHR;
         OPC_W'(OPC_SHL): dec.alu_op = ALU_SHL;
         OPC_W'(OPC_ROR): dec.alu_op = ALU_ROR;
         OPC_W'(OPC_ROL): dec.alu_op = ALU_ROL;
         OPC_W'(OPC_NEG): begin dec.alu_op = ALU_NEG; dec.unary = 1'b1; end
         OPC_W'(OPC_NOT): begin dec.alu_op = ALU_NOT; dec.unary = 1'b1; end
         default:         dec.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/rr_alu_sequencer.sv
// Fetch/decode/execute control sequencer for a single-bus register-register
// ALU datapath. Outputs are decoded from the state register and latched fields.
module rr_alu_sequencer
   import rr_alu_sequencer_pkg::*;
#(
   parameter int REG_BITS = 4,
   parameter int OPC_W    = 5,
   parameter int DATA_W   = 32
) (
   input  logic                 Clock,
   input  logic                 Reset_n,
   rr_alu_sequencer_if.slave    bus
);

   localparam int NUM_REGS = 2**REG_BITS;
   localparam int RA_HI    = DATA_W - OPC_W - 1;
   localparam int RB_HI    = RA_HI - REG_BITS;
   localparam int RC_HI    = RB_HI - REG_BITS;

   state_t              state_q, state_d;
   logic                first_q, first_d;
   logic [REG_BITS-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic                unary_q, unary_d;
   logic [3:0]          alu_op_q, alu_op_d;
   dec_t                dec;
   logic [REG_BITS-1:0] ra_live, rb_live, rc_live;
   logic [NUM_REGS-1:0] rout, rin;
   logic                unused_ir;

   assign ra_live   = bus.IR[RA_HI -: REG_BITS];
   assign rb_live   = bus.IR[RB_HI -: REG_BITS];
   assign rc_live   = bus.IR[RC_HI -: REG_BITS];
   assign unused_ir = ^bus.IR[RC_HI-REG_BITS:0];

   rr_opcode_decode #(.OPC_W(OPC_W)) u_dec (
      .opc (bus.IR[DATA_W-1 -: OPC_W]),
      .dec (dec)
   );

   always_comb begin
      state_d  = state_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rc_d     = rc_q;
      unary_d  = unary_q;
      alu_op_d = alu_op_q;
      // T1 is only ever entered from T0, so this marks its first cycle
      first_d  = (state_q == S_T0);
      case (state_q)
         S_IDLE: if (bus.Start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (bus.Mem_ready) state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            if (dec.legal) begin
               state_d  = S_T4;
               ra_d     = ra_live;
               rb_d     = rb_live;
               rc_d     = rc_live;
               unary_d  = dec.unary;
               alu_op_d = dec.alu_op;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_T4:   state_d = S_T5;
         S_T5:   state_d = bus.Start ? S_T0 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         first_q  <= 1'b0;
         ra_q     <= '0;
         rb_q     <= '0;
         rc_q     <= '0;
         unary_q  <= 1'b0;
         alu_op_q <= '0;
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rc_q     <= rc_d;
         unary_q  <= unary_d;
         alu_op_q <= alu_op_d;
      end
   end

   always_comb begin
      bus.PCout   = 1'b0;
      bus.Zlowout = 1'b0;
      bus.MDRout  = 1'b0;
      bus.MARin   = 1'b0;
      bus.Zin     = 1'b0;
      bus.PCin    = 1'b0;
      bus.MDRin   = 1'b0;
      bus.IRin    = 1'b0;
      bus.Yin     = 1'b0;
      bus.IncPC   = 1'b0;
      bus.Read    = 1'b0;
      bus.Alu_op  = 4'd0;
      bus.Done    = 1'b0;
      bus.Illegal = 1'b0;
      bus.Busy    = (state_q != S_IDLE);
      rout        = '0;
      rin         = '0;
      case (state_q)
         S_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
         end
         S_T1: begin
            bus.Zlowout = first_q;
            bus.PCin    = first_q;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         S_T3: begin
            // T3 still sees the freshly loaded IR, so Rb comes from it directly
            if (!dec.legal) begin
               bus.Illegal = 1'b1;
            end else if (!dec.unary) begin
               rout[rb_live] = 1'b1;
               bus.Yin       = 1'b1;
            end
         end
         S_T4: begin
            bus.Zin    = 1'b1;
            bus.Alu_op = alu_op_q;
            if (unary_q) rout[rb_q] = 1'b1;
            else         rout[rc_q] = 1'b1;
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            bus.Done    = 1'b1;
            rin[ra_q]   = 1'b1;
         end
         default: ;
      endcase
      bus.Rout = rout;
      bus.Rin  = rin;
   end

endmodule

// File: tb/tb_rr_alu_sequencer.sv
// Directed bench: walks each instruction cycle by cycle and compares every
// control output against hand-written per-state expectations.
module tb_rr_alu_sequencer;
   import rr_alu_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rr_alu_sequencer_if #(.REG_BITS(4), .DATA_W(32)) bus ();

   rr_alu_sequencer #(.REG_BITS(4), .OPC_W(5), .DATA_W(32)) dut (
      .Clock   (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   // strobe order: PCout Zlowout MDRout MARin Zin PCin MDRin IRin Yin IncPC Read
   localparam logic [10:0] ST_T0  = 11'b10011000010;
   localparam logic [10:0] ST_T1F = 11'b01000110001;
   localparam logic [10:0] ST_T1  = 11'b00000010001;
   localparam logic [10:0] ST_T2  = 11'b00100001000;
   localparam logic [10:0] ST_T3B = 11'b00000000100;
   localparam logic [10:0] ST_T4  = 11'b00001000000;
   localparam logic [10:0] ST_T5  = 11'b01000000000;
   localparam logic [2:0]  B      = 3'b100;  // Busy Done Illegal
   localparam logic [2:0]  BD     = 3'b110;
   localparam logic [2:0]  BI     = 3'b101;

   function automatic logic [49:0] obs();
      return {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin,
              bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read,
              bus.Busy, bus.Done, bus.Illegal, bus.Rout, bus.Rin, bus.Alu_op};
   endfunction

   function automatic logic [49:0] mk(logic [10:0] s, logic [2:0] st,
                                      logic [15:0] ro, logic [15:0] ri, logic [3:0] op);
      return {s, st, ro, ri, op};
   endfunction

   function automatic logic [31:0] ir(logic [4:0] opc, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
      return {opc, ra, rb, rc, 15'd0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.Start = 1'b1;
      bus.Mem_ready = 1'b1;
      bus.IR = 32'h28918000;
      #12;
      n_tests++;
      if (obs() !== 50'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected %h", obs(), 50'd0);
      end
      tick();
      n_tests++;
      if (obs() !== 50'd0) begin
         n_fail++;
         $display("FAIL reset_clocked: got %h expected %h", obs(), 50'd0);
      end
      bus.Start = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_and();
      logic [49:0] exp [7];
      exp[0] = mk(ST_T0,  B,  16'h0,    16'h0,    4'd0);
      exp[1] = mk(ST_T1F, B,  16'h0,    16'h0,    4'd0);
      exp[2] = mk(ST_T2,  B,  16'h0,    16'h0,    4'd0);
      exp[3] = mk(ST_T3B, B,  16'h0004, 16'h0,    4'd0);
      exp[4] = mk(ST_T4,  B,  16'h0008, 16'h0,    4'd2);
      exp[5] = mk(ST_T5,  BD, 16'h0,    16'h0002, 4'd0);
      exp[6] = 50'd0;
      bus.IR = 32'h28918000;
      bus.Mem_ready = 1'b1;
      bus.Start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         bus.Start = 1'b0;
         n_tests++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL and_row%0d: got %h expected %h", i, obs(), exp[i]);
         end
      end
   endtask

   task automatic test_rol();
      logic [49:0] exp [7];
      exp[0] = mk(ST_T0,  B,  16'h0,    16'h0,    4'd0);
      exp[1] = mk(ST_T1F, B,  16'h0,    16'h0,    4'd0);
      exp[2] = mk(ST_T2,  B,  16'h0,    16'h0,    4'd0);
      exp[3] = mk(ST_T3B, B,  16'h0040, 16'h0,    4'd0);
      exp[4] = mk(ST_T4,  B,  16'h0010, 16'h0,    4'd7);
      exp[5] = mk(ST_T5,  BD, 16'h0,    16'h0040, 4'd0);
      exp[6] = 50'd0;
      bus.IR = ir(5'b01010, 4'd6, 4'd6, 4'd4);
      bus.Mem_ready = 1'b1;
      bus.Start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         bus.Start = 1'b0;
         n_tests++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL rol_row%0d: got %h expected %h", i, obs(), exp[i]);
         end
      end
   endtask

   task automatic test_neg();
      logic [49:0] exp [7];
      exp[0] = mk(ST_T0,  B,  16'h0,    16'h0,    4'd0);
      exp[1] = mk(ST_T1F, B,  16'h0,    16'h0,    4'd0);
      exp[2] = mk(ST_T2,  B,  16'h0,    16'h0,    4'd0);
      exp[3] = mk(11'd0,  B,  16'h0,    16'h0,    4'd0);
      exp[4] = mk(ST_T4,  B,  16'h0020, 16'h0,    4'd8);
      exp[5] = mk(ST_T5,  BD, 16'h0,    16'h0004, 4'd0);
      exp[6] = 50'd0;
      bus.IR = ir(5'b10001, 4'd2, 4'd5, 4'd9);
      bus.Mem_ready = 1'b1;
      bus.Start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         bus.Start = 1'b0;
         n_tests++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL neg_row%0d: got %h expected %h", i, obs(), exp[i]);
         end
      end
   endtask

   task automatic test_mem_wait();
      logic [49:0] exp [10];
      exp[0] = mk(ST_T0,  B,  16'h0,    16'h0,    4'd0);
      exp[1] = mk(ST_T1F, B,  16'h0,    16'h0,    4'd0);
      exp[2] = mk(ST_T1,  B,  16'h0,    16'h0,    4'd0);
      exp[3] = mk(ST_T1,  B,  16'h0,    16'h0,    4'd0);
      exp[4] = mk(ST_T1,  B,  16'h0,    16'h0,    4'd0);
      exp[5] = mk(ST_T2,  B,  16'h0,    16'h0,    4'd0);
      exp[6] = mk(ST_T3B, B,  16'h0001, 16'h0,    4'd0);
      exp[7] = mk(ST_T4,  B,  16'h4000, 16'h0,    4'd1);
      exp[8] = mk(ST_T5,  BD, 16'h0,    16'h8000, 4'd0);
      exp[9] = 50'd0;
      bus.IR = ir(5'b00100, 4'd15, 4'd0, 4'd14);
      bus.Mem_ready = 1'b0;
      bus.Start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         bus.Start = 1'b0;
         bus.Mem_ready = (i == 4);
         n_tests++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL memwait_row%0d: got %h expected %h", i, obs(), exp[i]);
         end
      end
      bus.Mem_ready = 1'b1;
   endtask

   task automatic test_illegal();
      logic [4:0]  opcs [3];
      logic [49:0] exp [5];
      opcs[0] = 5'b11111;
      opcs[1] = 5'b01011;
      opcs[2] = 5'b00010;
      exp[0] = mk(ST_T0,  B,  16'h0, 16'h0, 4'd0);
      exp[1] = mk(ST_T1F, B,  16'h0, 16'h0, 4'd0);
      exp[2] = mk(ST_T2,  B,  16'h0, 16'h0, 4'd0);
      exp[3] = mk(11'd0,  BI, 16'h0, 16'h0, 4'd0);
      exp[4] = 50'd0;
      for (int k = 0; k < 3; k++) begin
         bus.IR = ir(opcs[k], 4'd1, 4'd2, 4'd3);
         bus.Mem_ready = 1'b1;
         bus.Start = 1'b1;
         for (int i = 0; i < 5; i++) begin
            tick();
            bus.Start = 1'b0;
            n_tests++;
            if (obs() !== exp[i]) begin
               n_fail++;
               $display("FAIL illegal_%b_row%0d: got %h expected %h", opcs[k], i, obs(), exp[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [49:0] exp [13];
      for (int j = 0; j < 2; j++) begin
         exp[j*6+0] = mk(ST_T0,  B,  16'h0,    16'h0,    4'd0);
         exp[j*6+1] = mk(ST_T1F, B,  16'h0,    16'h0,    4'd0);
         exp[j*6+2] = mk(ST_T2,  B,  16'h0,    16'h0,    4'd0);
         exp[j*6+3] = mk(ST_T3B, B,  16'h0002, 16'h0,    4'd0);
         exp[j*6+4] = mk(ST_T4,  B,  16'h0004, 16'h0,    4'd0);
         exp[j*6+5] = mk(ST_T5,  BD, 16'h0,    16'h0008, 4'd0);
      end
      exp[12] = 50'd0;
      bus.IR = ir(5'b00011, 4'd3, 4'd1, 4'd2);
      bus.Mem_ready = 1'b1;
      bus.Start = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         bus.Start = (i < 11);
         n_tests++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL b2b_row%0d: got %h expected %h", i, obs(), exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [49:0] exp [5];
      exp[0] = mk(ST_T0,  B, 16'h0,    16'h0, 4'd0);
      exp[1] = mk(ST_T1F, B, 16'h0,    16'h0, 4'd0);
      exp[2] = mk(ST_T2,  B, 16'h0,    16'h0, 4'd0);
      exp[3] = mk(ST_T3B, B, 16'h0004, 16'h0, 4'd0);
      exp[4] = mk(ST_T4,  B, 16'h0008, 16'h0, 4'd2);
      bus.IR = 32'h28918000;
      bus.Mem_ready = 1'b1;
      bus.Start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.Start = 1'b0;
         n_tests++;
         if (obs() !== exp[i]) begin
            n_fail++;
            $display("FAIL rstmid_row%0d: got %h expected %h", i, obs(), exp[i]);
         end
      end
      // mid-T4, away from any clock edge
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs() !== 50'd0) begin
         n_fail++;
         $display("FAIL rstmid_async: got %h expected %h", obs(), 50'd0);
      end
      tick();
      n_tests++;
      if (obs() !== 50'd0) begin
         n_fail++;
         $display("FAIL rstmid_held: got %h expected %h", obs(), 50'd0);
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (obs() !== 50'd0) begin
         n_fail++;
         $display("FAIL rstmid_no_done: got %h expected %h", obs(), 50'd0);
      end
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      n_tests++;
      if (obs() !== exp[0]) begin
         n_fail++;
         $display("FAIL rstmid_restart: got %h expected %h", obs(), exp[0]);
      end
      for (int i = 0; i < 6; i++) tick();
   endtask

   initial begin
      test_reset();
      test_and();
      test_rol();
      test_neg();
      test_mem_wait();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_alu_sequencer.md
RR_ALU_SEQUENCER -- requirements
Module: rr_alu_sequencer

Interface
REQ-001 Parameter REG_BITS, default 4: register-select field width; register count NUM_REGS = 2**REG_BITS.
REQ-002 Parameter OPC_W, default 5: opcode field width.
REQ-003 Parameter DATA_W, default 32: IR width; opcode is IR[DATA_W-1 -: OPC_W], then Ra, Rb, Rc fields of REG_BITS each, packed downward.
REQ-004 Clock  in  1  single clock; all state updates on the rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Start  in  1  request to begin one instruction.
REQ-007 Mem_ready  in  1  memory read data is valid on Mdatain.
REQ-008 IR  in  DATA_W  current instruction register contents.
REQ-009 PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath control strobes.
REQ-010 Rout, Rin  out  NUM_REGS  one-hot (or zero) register bus-drive and register-load selects.
REQ-011 Alu_op  out  4  ALU operation code; valid only while Zin is high in T4.
REQ-012 Busy, Done, Illegal  out  1 each  status: in progress, one-cycle completion pulse, one-cycle bad-opcode pulse.

Function
REQ-013 States: IDLE, T0, T1, T2, T3, T4, T5; all outputs are Moore-decoded from the state and the latched fields.
REQ-014 IDLE: all strobes 0; if Start is 1, go to T0.
REQ-015 T0: PCout, MARin, IncPC, Zin = 1; go to T1.
REQ-016 T1: Zlowout, PCin, Read, MDRin = 1; stay in T1 while Mem_ready = 0; go to T2 when Mem_ready = 1.
REQ-017 PCin and Zlowout are 1 only in the first T1 cycle; Read and MDRin stay 1 for every T1 cycle.
REQ-018 T2: MDRout, IRin = 1; go to T3.
REQ-019 T3: decode opcode from the live IR; latch Ra, Rb, Rc and Alu_op on leaving T3.
REQ-020 Opcode map: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010 (binary); NEG 10001 and NOT 10010 (unary).
REQ-021 T3, binary op: Rout[Rb] and Yin = 1. T3, unary op: no strobes. Both go to T4.
REQ-022 T3, opcode not in the map: Illegal = 1 for that cycle; go to IDLE; no register is written.
REQ-023 T4: Zin = 1 and Alu_op = latched code; Rout[Rc] = 1 for a binary op, Rout[Rb] = 1 for a unary op; go to T5.
REQ-024 T5: Zlowout, Rin[Ra], Done = 1; go to T0 if Start = 1, else go to IDLE.
REQ-025 Busy = 1 in every state except IDLE.
REQ-026 At most one bit of Rout and at most one bit of Rin is 1 in any cycle; Rin is nonzero only in T5.
REQ-027 Start is ignored in states T0 through T4.
REQ-028 Ra = Rb = Rc is legal; there is no hazard handling.
REQ-029 Minimum latency from Start sampled to Done is 6 cycles when Mem_ready is already 1 in the first T1 cycle.

Reset
REQ-030 While Reset_n = 0, the state is IDLE, the latched fields and Alu_op are 0, and every output is 0, regardless of Clock.
REQ-031 A reset asserted mid-instruction aborts it immediately; no partial Rin or Done pulse is produced.
REQ-032 Sequencing resumes on the first rising edge after Reset_n returns to 1.

Structure
REQ-033 A shared package holds the state encoding (4-bit: IDLE 0000, T0–T5 0111–1100), the opcode constants, and the Alu_op constants.
REQ-034 Alu_op constants: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, ROR 6, ROL 7, NEG 8, NOT 9.
REQ-035 One sub-module, rr_opcode_decode, is combinational and maps the opcode to (legal, unary, Alu_op).

Verification
REQ-036 Scenario: IR = 0x28918000 (AND R1,R2,R3) and Mem_ready tied to 1 -> T3 gives Rout = 0x0004 with Yin; T4 gives Rout = 0x0008 with Alu_op = 2; T5 gives Rin = 0x0002 with Done; 6 cycles total.
REQ-037 Scenario: ROL opcode 01010 with Ra = 6, Rb = 6, Rc = 4 -> Alu_op = 7 in T4; T5 gives Rin = 0x0040.
REQ-038 Scenario: Mem_ready held low for 3 cycles in T1 -> T1 lasts 4 cycles; PCin is high only in the first; Read is high in all 4.
REQ-039 Scenario: opcode 11111 -> Illegal pulses in T3; next state is IDLE; Rin stays 0 throughout.
REQ-040 Scenario: Start held high -> T5 goes directly to T0; Done pulses once per instruction; Busy never drops.
REQ-041 Scenario: Reset_n pulsed low during T4 -> all outputs go to 0 asynchronously; there is no Done or Rin pulse; the next Start begins at T0.
